dm_arbiter: RTL and testbench

Round-robin arbiter sharing the single-port 8-bit data memory (DM) among several requesters. Typical requesters are the core's load/store unit, a bench/boot preload port, and a debug reader. Sits between the requesters and the DM macro inside `top_level`. It issues at most one memory access per cycle and routes read data back to the winner with a one-cycle tag pipeline. An optional bus-lock feature supports atomic read-modify-write.

---
 rtl/dm_arb_pkg.sv | 14 +
 rtl/rr_picker.sv | 34 +++
 rtl/dm_arbiter.sv | 136 +++++++++++++
 tb/tb_dm_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The bus-lock feature is compiled in with the DM_ARB_LOCK_EN macro.
package dm_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int DM_AW   = 8;
    localparam int DM_DW   = 8;
    localparam int MAX_REQ = 4;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping modulo N. Output pick is one-hot; any flags a valid pick.
module rr_picker #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] rr_ptr,
    output logic [N-1:0]  pick,
    output logic          any
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    always_comb begin
        pick = '0;
        any  = 1'b0;
        sum  = '0;
        idx  = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!any && req[idx]) begin
                pick[idx] = 1'b1;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one single-port DM among NUM_REQ requesters.
// Define DM_ARB_LOCK_EN to enable the bus-lock (atomic RMW) feature.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int AW      = DM_AW,
    parameter int DW      = DM_DW
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    we,
    input  logic [NUM_REQ*AW-1:0] addr,
    input  logic [NUM_REQ*DW-1:0] wdata,
    input  logic [NUM_REQ-1:0]    lock,
    input  logic                  quiesce,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rvalid,
    output logic [DW-1:0]         rdata,
    output logic                  idle,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    input  logic [DW-1:0]         mem_rdata
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t        state_q, state_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     tag_q, tag_d;
    logic              tag_v_q, tag_v_d;
    logic              idle_q, idle_d;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] pick;
    logic               any;
    logic [PW-1:0]      win_idx;

    // Reset gates the combinational grant path so outputs sit at reset values.
    always_comb begin
        elig = req;
        if (state_q == LOCKED) begin
            elig = req & (NUM_REQ'(1) << owner_q);
        end
        if (!Reset || quiesce) begin
            elig = '0;
        end
    end

    rr_picker #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_picker (
        .req    (elig),
        .rr_ptr (rr_ptr_q),
        .pick   (pick),
        .any    (any)
    );

    always_comb begin
        win_idx   = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                win_idx   = PW'(i);
                mem_we    = we[i];
                mem_addr  = addr[i*AW +: AW];
                mem_wdata = wdata[i*DW +: DW];
            end
        end
    end

    assign gnt    = pick;
    assign mem_en = any;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        tag_d    = tag_q;
        tag_v_d  = any && !mem_we;
        if (any && !mem_we) begin
            tag_d = win_idx;
        end
        case (state_q)
            ARB: begin
                if (any) begin
                    rr_ptr_d = (win_idx == PW'(NUM_REQ-1)) ? '0 : win_idx + PW'(1);
`ifdef DM_ARB_LOCK_EN
                    if (lock[win_idx]) begin
                        state_d = LOCKED;
                        owner_d = win_idx;
                    end
`endif
                end
            end
            LOCKED: begin
                if (!lock[owner_q] && !req[owner_q]) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
        idle_d = !tag_v_d && (state_d == ARB);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ARB;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            tag_q    <= '0;
            tag_v_q  <= 1'b0;
            idle_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            tag_q    <= tag_d;
            tag_v_q  <= tag_v_d;
            idle_q   <= idle_d;
        end
    end

    // DM read data is already registered in the macro; only the tag is ours.
    assign rvalid = tag_v_q ? (NUM_REQ'(1) << tag_q) : '0;
    assign rdata  = tag_v_q ? mem_rdata : '0;
    assign idle   = idle_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed steps followed by random traffic,
// compared each cycle against a behavioural arbitration/memory model.
module tb_dm_arbiter;

    localparam int N  = 2;
    localparam int AW = 8;
    localparam int DW = 8;

    logic            Clk = 1'b0;
    logic            Reset;
    logic [N-1:0]    req, we, lock;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic            quiesce;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata;
    logic            idle, mem_en, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata = '0;

    logic [DW-1:0]   dm [256];

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    int            m_ptr;
    bit            m_rv_v;
    int            m_rv_idx;
    logic [DW-1:0] m_rv_data;
    bit            m_idle;
    bit            m_locked;
    int            m_owner;
    logic [DW-1:0] m_mem [256];
    int            last_w;

    dm_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .lock      (lock),
        .quiesce   (quiesce),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .idle      (idle),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 Clk = ~Clk;

    // DM macro: registered read, one cycle latency
    always @(posedge Clk) begin
        if (mem_en) begin
            if (mem_we) dm[mem_addr] <= mem_wdata;
            else        mem_rdata    <= dm[mem_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr    = 0;
        m_rv_v   = 0;
        m_rv_idx = 0;
        m_idle   = 1;
        m_locked = 0;
        m_owner  = 0;
        last_w   = -1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]            = 1'b1;
        we[i]             = w;
        addr[i*AW +: AW]  = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic clr_req(input int i);
        req[i] = 1'b0;
    endtask

    // One clock cycle: check outputs at negedge against the model, then advance it.
    task automatic step();
        int            w;
        int            idx;
        logic [N-1:0]  g_exp, rv_exp;
        logic [AW-1:0] wa;
        @(negedge Clk);
        w = -1;
        if (Reset && !quiesce) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (w < 0 && req[idx] && (!m_locked || idx == m_owner)) w = idx;
            end
        end
        g_exp  = (w >= 0) ? N'(1 << w) : '0;
        rv_exp = m_rv_v ? N'(1 << m_rv_idx) : '0;
        chk("gnt", 32'(gnt), 32'(g_exp));
        chk("mem_en", 32'(mem_en), (w >= 0) ? 32'd1 : 32'd0);
        chk("rvalid", 32'(rvalid), 32'(rv_exp));
        chk("idle", 32'(idle), 32'(m_idle));
        if (m_rv_v) chk("rdata", 32'(rdata), 32'(m_rv_data));
        if (w >= 0) begin
            chk("mem_we", 32'(mem_we), 32'(we[w]));
            chk("mem_addr", 32'(mem_addr), 32'(addr[w*AW +: AW]));
            if (we[w]) chk("mem_wdata", 32'(mem_wdata), 32'(wdata[w*DW +: DW]));
        end else if (!Reset) begin
            chk("rst_rdata", 32'(rdata), 32'd0);
            chk("rst_mem_we", 32'(mem_we), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        end
        @(posedge Clk);
        #1;
        if (!Reset) begin
            model_reset();
            return;
        end
        m_rv_v = (w >= 0) && !we[w];
        if (w >= 0) begin
            wa = addr[w*AW +: AW];
            m_rv_idx  = w;
            m_rv_data = m_mem[wa];
            if (we[w]) m_mem[wa] = wdata[w*DW +: DW];
        end
        if (m_locked) begin
            if (!lock[m_owner] && !req[m_owner]) m_locked = 0;
        end else if (w >= 0) begin
            m_ptr = (w + 1) % N;
`ifdef DM_ARB_LOCK_EN
            if (lock[w]) begin
                m_locked = 1;
                m_owner  = w;
            end
`endif
        end
        m_idle = !m_rv_v && !m_locked;
        last_w = w;
    endtask

    // Hold a request until the model says it was granted, bounded.
    task automatic issue(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got;
        got = 0;
        set_req(i, w, a, d);
        for (int t = 0; t < 8 && !got; t++) begin
            step();
            if (last_w == i) got = 1;
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $error("FAIL issue_timeout requester=%0d observed=no_grant expected=grant", i);
        end
        clr_req(i);
    endtask

    initial begin
        req = '0; we = '0; lock = '0; addr = '0; wdata = '0; quiesce = 1'b0;
        for (int a = 0; a < 256; a++) m_mem[a] = '0;
        Reset = 1'b0;
        model_reset();
        repeat (2) step();
        Reset = 1'b1;
        step();

        // preload DM through requester 1
        for (int a = 7; a >= 0; a--) begin
            issue(1, 1'b1, AW'(a), (a == 0) ? 8'hF0 : (a == 1) ? 8'hCC : 8'($urandom_range(0, 255)));
        end
        step();

        // single read of addr 0
        issue(0, 1'b0, 8'h00, 8'h00);
        step();

        // contention on addr 1
        set_req(0, 1'b0, 8'h01, 8'h00);
        set_req(1, 1'b0, 8'h01, 8'h00);
        repeat (4) step();
        clr_req(0);
        clr_req(1);
        step();

        // write then read
        issue(1, 1'b1, 8'h02, 8'hBC);
        issue(0, 1'b0, 8'h02, 8'h00);
        step();

        // quiesce with a read in flight and req0 still pending
        set_req(0, 1'b0, 8'h00, 8'h00);
        step();
        quiesce = 1'b1;
        repeat (2) step();
        quiesce = 1'b0;
        step();
        clr_req(0);
        step();

        // reset while a read is in flight
        set_req(1, 1'b0, 8'h01, 8'h00);
        step();
        Reset = 1'b0;
        model_reset();
        clr_req(1);
        repeat (2) step();
        Reset = 1'b1;
        repeat (2) step();

`ifdef DM_ARB_LOCK_EN
        lock[0] = 1'b1;
        set_req(0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 8'h00, 8'h00);
        repeat (2) step();
        set_req(0, 1'b1, 8'h00, 8'h0F);
        repeat (2) step();
        clr_req(0);
        lock[0] = 1'b0;
        repeat (3) step();
        clr_req(1);
        repeat (2) step();
`endif

        // random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                            DW'($urandom_range(0, 255)));
                end
            end
            quiesce = ($urandom_range(0, 9) == 0);
            step();
            if (last_w >= 0) clr_req(last_w);
        end
        quiesce = 1'b0;
        req = '0;
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
